// File: rtl/decode_scoreboard.sv
// rtl/decode_scoreboard.sv - per-register pending-write scoreboard producing the decode RAW stall.
// Optional same-cycle writeback release is enabled by defining SCOREBOARD_WB_BYPASS_EN.
module decode_scoreboard #(
  parameter int NR_REGS = 32,
  parameter int CNT_W   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] rs1_i,
  input  logic       rs1_ren_i,
  input  logic [4:0] rs2_i,
  input  logic       rs2_ren_i,
  input  logic [4:0] rd_i,
  input  logic       rd_wen_i,
  input  logic       issue_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_wen_i,
  input  logic       flush_i,
  output logic       raw_o,
  output logic       full_o,
  output logic [5:0] inflight_o,
  output logic       err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               TOT_W   = 16;

  logic [CNT_W-1:0] cnt_q [1:NR_REGS-1];
  logic [CNT_W-1:0] cnt_d [1:NR_REGS-1];
  logic [TOT_W-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
  logic             issue_ev, retire_ev, same_reg;
  logic             issue_ok, issue_err, retire_ok, retire_err;
  logic             rs1_haz, rs2_haz;

  // x0 is never matched by the loop, so its lookups stay at zero.
  always_comb begin
    rs1_cnt = '0;
    rs2_cnt = '0;
    rd_cnt  = '0;
    wb_cnt  = '0;
    for (int i = 1; i < NR_REGS; i++) begin
      if (rs1_i == 5'(i))   rs1_cnt = cnt_q[i];
      if (rs2_i == 5'(i))   rs2_cnt = cnt_q[i];
      if (rd_i == 5'(i))    rd_cnt  = cnt_q[i];
      if (wb_rd_i == 5'(i)) wb_cnt  = cnt_q[i];
    end
  end

  // A same-register issue/retire pair cancels out and is never an error.
  always_comb begin
    issue_ev   = issue_i && rd_wen_i && (rd_i != 5'd0);
    retire_ev  = wb_wen_i && (wb_rd_i != 5'd0);
    same_reg   = issue_ev && retire_ev && (rd_i == wb_rd_i);
    issue_ok   = issue_ev && !same_reg && (rd_cnt != CNT_MAX);
    issue_err  = issue_ev && !same_reg && (rd_cnt == CNT_MAX);
    retire_ok  = retire_ev && !same_reg && (wb_cnt != '0);
    retire_err = retire_ev && !same_reg && (wb_cnt == '0);
  end

  always_comb begin
    rs1_haz = rs1_ren_i && (rs1_cnt != '0);
    rs2_haz = rs2_ren_i && (rs2_cnt != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wb_wen_i && (wb_rd_i == rs1_i) && (rs1_cnt == CNT_W'(1))) rs1_haz = 1'b0;
    if (wb_wen_i && (wb_rd_i == rs2_i) && (rs2_cnt == CNT_W'(1))) rs2_haz = 1'b0;
`endif
    full_o = rd_wen_i && (rd_i != 5'd0) && (rd_cnt == CNT_MAX);
    raw_o  = rs1_haz || rs2_haz || full_o;
  end

  always_comb begin
    for (int i = 1; i < NR_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    inflight_d = inflight_q;
    err_d      = err_q;
    if (flush_i) begin
      for (int i = 1; i < NR_REGS; i++) begin
        cnt_d[i] = '0;
      end
      inflight_d = '0;
    end else begin
      for (int i = 1; i < NR_REGS; i++) begin
        if (issue_ok && (rd_i == 5'(i)))     cnt_d[i] = cnt_q[i] + CNT_W'(1);
        if (retire_ok && (wb_rd_i == 5'(i))) cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      case ({issue_ok, retire_ok})
        2'b10:   inflight_d = inflight_q + TOT_W'(1);
        2'b01:   inflight_d = inflight_q - TOT_W'(1);
        default: inflight_d = inflight_q;
      endcase
      if (issue_err || retire_err) err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NR_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 1; i < NR_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign inflight_o = (inflight_q > TOT_W'(63)) ? 6'd63 : inflight_q[5:0];
  assign err_o      = err_q;

endmodule

// File: doc/decode_scoreboard.md
# decode_scoreboard

Register-hazard scoreboard for the decode stage: tracks outstanding writes to each general-purpose register and produces the read-after-write stall flag (`raw_o`) that the decode handshake controller consumes. It sits between decode (which reports issued instructions) and writeback (which reports retired register writes). It also detects write-after-write saturation and inconsistent retirements.

## Interface
- `NR_REGS`, default 32: number of architectural registers; index 0 is hard-wired zero.
- `CNT_W`, default 2: width of each per-register pending counter; max outstanding writes per register = 2^CNT_W − 1.
- `clock` input 1: single clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `rs1_i` input 5: first source register of the instruction in decode.
- `rs1_ren_i` input 1: rs1 is actually read.
- `rs2_i` input 5: second source register.
- `rs2_ren_i` input 1: rs2 is actually read.
- `rd_i` input 5: destination register of the instruction in decode.
- `rd_wen_i` input 1: instruction writes rd.
- `issue_i` input 1: decode → execute handshake fired this cycle (valid && ready).
- `wb_rd_i` input 5: register written back this cycle.
- `wb_wen_i` input 1: writeback performs a register write this cycle.
- `flush_i` input 1: synchronous clear of all pending state (pipeline flush).
- `raw_o` output 1: hazard; decode must not issue.
- `full_o` output 1: rd counter is saturated.
- `inflight_o` output 6: total outstanding tracked writes, saturating at 63.
- `err_o` output 1: sticky protocol error flag.

## Operation
- One `CNT_W`-bit counter per register 1..NR_REGS−1; register 0 is never tracked (issue/writeback to x0 ignored, reads of x0 never hazard).
- Issue event: `issue_i && rd_wen_i && rd_i != 0` → increment `cnt[rd_i]`.
- Retire event: `wb_wen_i && wb_rd_i != 0` → decrement `cnt[wb_rd_i]`.
- Same register issued and retired in the same cycle → counter unchanged; different registers → both updated.
- `full_o` = `rd_wen_i && rd_i != 0 && cnt[rd_i] == max`.
- `raw_o` = (`rs1_ren_i` && `cnt[rs1_i] != 0`) || (`rs2_ren_i` && `cnt[rs2_i] != 0`) || `full_o`.
- Issue into a saturated counter: increment suppressed, `err_o` set.
- Retire on a zero counter: decrement suppressed, `err_o` set.
- `inflight_o` tracks the sum of all counters: +1 per accepted issue, −1 per accepted retire, net 0 when both are accepted.
- `flush_i`: all counters and `inflight_o` cleared at the next edge. Issue/retire in the same cycle are discarded. `err_o` is unaffected.
- `err_o` clears only on `reset`.

## Timing
- Reset values: all counters 0, `inflight_o` = 0, `err_o` = 0. Therefore `raw_o` = 0 and `full_o` = 0 whenever reset is asserted.
- `raw_o` and `full_o` are combinational from the registered counters and the current-cycle decode inputs; no registered output path.
- Issue at edge N → a dependent reader sees `raw_o` = 1 from cycle N+1 onward.
- Retire at cycle N (without bypass) → `raw_o` deasserts in cycle N+1 if no writes remain.
- Reset asserted mid-operation: state clears asynchronously, regardless of `issue_i`/`wb_wen_i`.
- Decode must hold the instruction while `raw_o` = 1. The scoreboard accepts `issue_i` unconditionally; the hazard is the caller's responsibility, and only saturation is flagged via `err_o`.

## Configuration
- `SCOREBOARD_WB_BYPASS_EN`, when defined: a source counts as ready in the same cycle its last pending write retires. Condition: `cnt == 1`, `wb_wen_i`, and `wb_rd_i` matches. The hazard term for that source is masked, giving a 1-cycle-earlier release; writeback data must then be forwarded by the register file.
- Without the macro: `raw_o` depends only on the registered counters, and the release is one cycle after retire.

## Test plan
- Reset, then read rs1=5, rs2=6 with no issues → `raw_o`=0, `inflight_o`=0, `err_o`=0.
- Issue rd=5 at cycle 1, then read rs1=5 → `raw_o`=1 from cycle 2. Retire wb_rd=5 at cycle 4 → `raw_o`=0 in cycle 5 without the macro, in cycle 4 with `SCOREBOARD_WB_BYPASS_EN`.
- Issue rd=0 and read rs1=0 → `raw_o`=0, `inflight_o` stays 0.
- CNT_W=2: three issues to rd=7 → `full_o`=1 and `raw_o`=1 with rd_i=7. A fourth forced issue → `err_o`=1 and `inflight_o` stays 3.
- Issue rd=9 and retire wb_rd=9 in the same cycle with cnt[9]=1 → cnt[9] stays 1. Then retire on x10 with cnt=0 → `err_o`=1.
- With 4 registers pending, pulse `flush_i` → next cycle `inflight_o`=0, `raw_o`=0. Assert `reset` between clock edges → all outputs 0 immediately, including `err_o`.
